// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, single-outstanding imem requests,
// and an output register backed by a one-entry skid buffer toward the decoder.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INSN = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        hold_pc,
    input  logic        return_pc,
    input  logic        redirect_val,
    input  logic [15:0] redirect_pc,
    output logic [15:0] q,
    output logic        q_val,
    output logic [15:0] q_pc
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DROP  = 3'd2,
        FULL  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] addr_reg, addr_next;
    logic [15:0] pend_pc_reg, pend_pc_next;
    logic        to_hold_reg, to_hold_next;
    logic [15:0] q_reg, q_next;
    logic [15:0] q_pc_reg, q_pc_next;
    logic        q_val_reg, q_val_next;
    logic [15:0] skid_reg, skid_next;
    logic [15:0] skid_pc_reg, skid_pc_next;
    logic        skid_val_reg, skid_val_next;

    // A request is on the bus but not accepted this cycle; it must stay stable.
    logic waiting;
    logic hold_take;

    assign waiting   = imem_req && !imem_ack;
    assign hold_take = hold_pc && (state_reg != DROP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (redirect_val) begin
            state_next = waiting ? DROP : FETCH;
        end else if (hold_take) begin
            state_next = waiting ? DROP : HOLD;
        end else begin
            case (state_reg)
                IDLE:    state_next = FETCH;
                FETCH:   if (imem_ack && q_val_reg && stall) state_next = FULL;
                DROP:    if (imem_ack) state_next = to_hold_reg ? HOLD : FETCH;
                FULL:    if (!stall) state_next = FETCH;
                default: state_next = state_reg;
            endcase
        end
    end

    always_comb begin
        imem_req  = (state_reg == FETCH) || (state_reg == DROP);
        imem_addr = addr_reg;
        q         = q_val_reg ? q_reg : NOP_INSN;
        q_val     = q_val_reg;
        q_pc      = q_pc_reg;
    end

    always_comb begin
        addr_next     = addr_reg;
        pend_pc_next  = pend_pc_reg;
        to_hold_next  = to_hold_reg;
        q_next        = q_reg;
        q_pc_next     = q_pc_reg;
        q_val_next    = q_val_reg;
        skid_next     = skid_reg;
        skid_pc_next  = skid_pc_reg;
        skid_val_next = skid_val_reg;
        if (redirect_val) begin
            q_val_next    = 1'b0;
            skid_val_next = 1'b0;
            to_hold_next  = 1'b0;
            if (waiting) begin
                pend_pc_next = redirect_pc;
            end else begin
                addr_next = redirect_pc;
            end
        end else if (hold_take) begin
            q_val_next    = 1'b0;
            skid_val_next = 1'b0;
            if (waiting) begin
                to_hold_next = 1'b1;
            end
        end else begin
            case (state_reg)
                FETCH: begin
                    if (imem_ack) begin
                        addr_next = addr_reg + 16'd1;
                        if (q_val_reg && stall) begin
                            skid_next     = imem_rdata;
                            skid_pc_next  = addr_reg;
                            skid_val_next = 1'b1;
                        end else begin
                            q_next     = imem_rdata;
                            q_pc_next  = addr_reg;
                            q_val_next = 1'b1;
                        end
                    end else if (!stall) begin
                        q_val_next = 1'b0;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        addr_next    = pend_pc_reg;
                        to_hold_next = 1'b0;
                    end
                end
                FULL: begin
                    if (!stall) begin
                        q_next        = skid_reg;
                        q_pc_next     = skid_pc_reg;
                        q_val_next    = 1'b1;
                        skid_val_next = 1'b0;
                    end
                end
                default: begin
                    if (!stall) q_val_next = 1'b0;
                end
            endcase
        end
        if (hold_pc) skid_val_next = 1'b0;
        if (return_pc || hold_pc) q_val_next = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_reg     <= RESET_PC;
            pend_pc_reg  <= RESET_PC;
            to_hold_reg  <= 1'b0;
            q_reg        <= NOP_INSN;
            q_pc_reg     <= RESET_PC;
            q_val_reg    <= 1'b0;
            skid_reg     <= NOP_INSN;
            skid_pc_reg  <= RESET_PC;
            skid_val_reg <= 1'b0;
        end else begin
            addr_reg     <= addr_next;
            pend_pc_reg  <= pend_pc_next;
            to_hold_reg  <= to_hold_next;
            q_reg        <= q_next;
            q_pc_reg     <= q_pc_next;
            q_val_reg    <= q_val_next;
            skid_reg     <= skid_next;
            skid_pc_reg  <= skid_pc_next;
            skid_val_reg <= skid_val_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run checked against
// a program-order model of the instruction stream the decoder should consume.
module tb_fetch_unit;

    localparam logic [15:0] RST_PC = 16'h0000;
    localparam logic [15:0] NOP    = 16'hE000;

    logic        clk, rst;
    logic        imem_req, imem_ack;
    logic [15:0] imem_addr, imem_rdata;
    logic        stall, hold_pc, return_pc, redirect_val;
    logic [15:0] redirect_pc;
    logic [15:0] q, q_pc;
    logic        q_val;

    int          n_cmp, n_err, mem_lat, wait_cnt, consumed, consumed_base;
    logic [15:0] mem_key, exp_pc, prev_addr, keep_q, keep_pc;
    bit          stray_en, held, pend, prev_req, prev_hold, flush, stall_keep;

    fetch_unit #(
        .RESET_PC (RST_PC),
        .NOP_INSN (NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .hold_pc      (hold_pc),
        .return_pc    (return_pc),
        .redirect_val (redirect_val),
        .redirect_pc  (redirect_pc),
        .q            (q),
        .q_val        (q_val),
        .q_pc         (q_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem(input logic [15:0] a);
        return a ^ mem_key;
    endfunction

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input logic st, input logic hp, input logic rv, input logic [15:0] rpc);
        logic ack;
        if (!q_val) check_eq("nop_when_invalid", q, NOP);
        if (pend) begin
            check_eq("req_stable", 16'(imem_req), 16'd1);
            check_eq("addr_stable", imem_addr, prev_addr);
        end
        if (held && !prev_req) check_eq("hold_no_req", 16'(imem_req), 16'd0);
        if (held) check_eq("hold_qval", 16'(q_val), 16'd0);

        ack = 1'b0;
        if (imem_req) begin
            ack = (mem_lat < 0) ? ($urandom_range(0, 2) != 0) : (wait_cnt >= mem_lat);
            wait_cnt = ack ? 0 : wait_cnt + 1;
        end else begin
            wait_cnt = 0;
            if (stray_en) ack = ($urandom_range(0, 3) == 0);
        end
        imem_ack     = ack;
        imem_rdata   = (ack && imem_req) ? mem(imem_addr) : 16'($urandom);
        stall        = st;
        hold_pc      = hp;
        redirect_val = rv;
        redirect_pc  = rpc;
        return_pc    = prev_hold;

        if (rv) begin
            exp_pc = rpc;
            held   = 1'b0;
        end else begin
            if (q_val && !st) begin
                check_eq("q_pc_order", q_pc, exp_pc);
                check_eq("q_data", q, mem(exp_pc));
                $display("insn pc=%h q=%h", q_pc, q);
                exp_pc = exp_pc + 16'd1;
                consumed++;
            end
            if (hp) held = 1'b1;
        end
        flush      = rv || hp;
        stall_keep = q_val && st && !rv && !hp && !return_pc;
        keep_q     = q;
        keep_pc    = q_pc;
        pend       = imem_req && !ack;
        prev_addr  = imem_addr;
        prev_req   = imem_req;
        prev_hold  = hp;

        @(posedge clk);
        @(negedge clk);
        if (flush) check_eq("flush_qval", 16'(q_val), 16'd0);
        if (stall_keep) begin
            check_eq("stall_qval", 16'(q_val), 16'd1);
            check_eq("stall_q", q, keep_q);
            check_eq("stall_pc", q_pc, keep_pc);
        end
    endtask

    task automatic step();
        cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    // Reset is applied between clock edges; outputs must clear immediately.
    task automatic apply_reset(input logic late_ack);
        #2;
        rst          = 1'b0;
        imem_ack     = late_ack;
        imem_rdata   = 16'hBAD0;
        stall        = 1'b0;
        hold_pc      = 1'b0;
        return_pc    = 1'b0;
        redirect_val = 1'b0;
        redirect_pc  = 16'h0000;
        #1;
        check_eq("rst_req", 16'(imem_req), 16'd0);
        check_eq("rst_addr", imem_addr, RST_PC);
        check_eq("rst_qval", 16'(q_val), 16'd0);
        check_eq("rst_q", q, NOP);
        check_eq("rst_qpc", q_pc, RST_PC);
        @(posedge clk);
        @(negedge clk);
        rst        = 1'b1;
        exp_pc     = RST_PC;
        held       = 1'b0;
        pend       = 1'b0;
        prev_req   = 1'b0;
        prev_hold  = 1'b0;
        flush      = 1'b0;
        stall_keep = 1'b0;
        wait_cnt   = 0;
    endtask

    initial begin
        logic st, hp, rv;
        logic [15:0] rpc;
        n_cmp = 0; n_err = 0; consumed = 0; wait_cnt = 0;
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 16'h0000; stall = 1'b0;
        hold_pc = 1'b0; return_pc = 1'b0; redirect_val = 1'b0; redirect_pc = 16'h0000;
        mem_lat = 0; mem_key = 16'h0000; stray_en = 1'b0;
        held = 1'b0; pend = 1'b0; prev_req = 1'b0; prev_hold = 1'b0;
        exp_pc = RST_PC;

        // Reset release, zero-wait memory returning the address as data
        @(negedge clk);
        apply_reset(1'b0);
        check_eq("idle_no_req", 16'(imem_req), 16'd0);
        step();
        check_eq("first_req", 16'(imem_req), 16'd1);
        check_eq("first_addr", imem_addr, RST_PC);
        check_eq("first_qval_late", 16'(q_val), 16'd0);
        step();
        check_eq("first_qval", 16'(q_val), 16'd1);
        check_eq("first_q", q, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stream_q", q, 16'(i + 1));
        end

        // Stall three cycles while q holds word 5
        for (int i = 0; i < 10 && !(q_val && q_pc == 16'h0005); i++) step();
        check_eq("reach5", q_pc, 16'h0005);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 16'h0000);
            check_eq("stall_hold_q", q, 16'h0005);
            check_eq("full_no_req", 16'(imem_req), 16'd0);
        end
        step();
        check_eq("unstall_q6", q, 16'h0006);
        step();
        check_eq("unstall_q7", q, 16'h0007);

        // hold_pc on a RETURN word, then resume via redirect
        cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        check_eq("hold_qval0", 16'(q_val), 16'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("hold_idle_req", 16'(imem_req), 16'd0);
        end
        cycle(1'b0, 1'b0, 1'b1, 16'h0040);
        check_eq("resume_req", 16'(imem_req), 16'd1);
        check_eq("resume_addr", imem_addr, 16'h0040);
        for (int i = 0; i < 5 && !q_val; i++) step();
        check_eq("resume_qpc", q_pc, 16'h0040);

        // PC wrap at 16'hFFFF
        mem_key = 16'h5A3C;
        cycle(1'b0, 1'b0, 1'b1, 16'hFFFD);
        for (int i = 0; i < 10 && !(q_val && q_pc == 16'hFFFF); i++) step();
        check_eq("reach_ffff", q_pc, 16'hFFFF);
        step();
        check_eq("wrap_qpc", q_pc, 16'h0000);
        check_eq("wrap_qval", 16'(q_val), 16'd1);

        // Redirect against a slow pending request
        mem_lat = 3;
        cycle(1'b0, 1'b0, 1'b1, 16'h0010);
        for (int i = 0; i < 20 && !(imem_req && imem_addr == 16'h0010); i++) step();
        check_eq("reach_10", imem_addr, 16'h0010);
        cycle(1'b0, 1'b0, 1'b1, 16'h0100);
        check_eq("stale_req", 16'(imem_req), 16'd1);
        check_eq("stale_addr", imem_addr, 16'h0010);
        for (int i = 0; i < 10 && imem_addr == 16'h0010; i++) step();
        check_eq("target_addr", imem_addr, 16'h0100);
        check_eq("target_req", 16'(imem_req), 16'd1);
        for (int i = 0; i < 10 && !q_val; i++) step();
        check_eq("target_qpc", q_pc, 16'h0100);
        check_eq("target_q", q, mem(16'h0100));

        // Reset during a pending request at 16'h0022, late ack afterwards
        cycle(1'b0, 1'b0, 1'b1, 16'h0020);
        for (int i = 0; i < 40 && !(imem_req && imem_addr == 16'h0022); i++) step();
        check_eq("reach_22", imem_addr, 16'h0022);
        step();
        apply_reset(1'b1);
        @(posedge clk);
        @(negedge clk);
        imem_ack = 1'b0;
        check_eq("late_ack_qval", 16'(q_val), 16'd0);
        check_eq("restart_req", 16'(imem_req), 16'd1);
        check_eq("restart_addr", imem_addr, RST_PC);
        mem_lat = 0;
        for (int i = 0; i < 5 && !q_val; i++) step();
        check_eq("restart_qpc", q_pc, RST_PC);
        check_eq("restart_q", q, mem(RST_PC));

        // Randomized traffic: random ack latency, stalls, redirects, holds, stray acks
        mem_lat = -1;
        stray_en = 1'b1;
        consumed_base = consumed;
        for (int i = 0; i < 3000; i++) begin
            st = ($urandom_range(0, 3) == 0);
            rv = 1'b0;
            hp = 1'b0;
            if (held) rv = ($urandom_range(0, 3) == 0);
            else if ($urandom_range(0, 39) == 0) rv = 1'b1;
            else if (q_val && !st && $urandom_range(0, 59) == 0) hp = 1'b1;
            if ($urandom_range(0, 1) == 0) rpc = 16'($urandom);
            else rpc = 16'hFFF0 + 16'($urandom_range(0, 15));
            cycle(st, hp, rv, rpc);
        end
        check_eq("progress", 16'(consumed - consumed_base > 300), 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the decoder. It holds the program counter, issues single-outstanding requests to instruction memory, and presents one 16-bit instruction word per cycle on `q` through a one-entry skid buffer. It reacts to the decoder's `hold_pc` and `return_pc` and to branch/call/return redirects from execute.

## Interface
Parameters:
- `RESET_PC`, 16'h0000: PC loaded at reset.
- `NOP_INSN`, 16'h0000: word driven on `q` whenever `q_val`=0. This value must decode to no architectural effect.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  16  word address of the request.
- `imem_ack`  in  1  request accepted. `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  16  instruction word.
- `stall`  in  1  downstream cannot take a new `q` this cycle.
- `hold_pc`  in  1  from decoder: current `q` is RETURN/RTI.
- `return_pc`  in  1  from decoder: registered follow-up of `hold_pc`.
- `redirect_val`  in  1  load a new PC (branch taken, CALL, RETURN/RTI target).
- `redirect_pc`  in  16  target word address.
- `q`  out  16  instruction to decoder.
- `q_val`  out  1  `q` holds a real instruction.
- `q_pc`  out  16  address of `q`.

## Operation
- Memory protocol:
  - `imem_req` and `imem_addr` stay stable from assertion until the cycle `imem_ack`=1.
  - At most one request is outstanding.
  - `imem_ack` while `imem_req`=0 is ignored.
- PC:
  - Word-addressed; increments by 1 per accepted fetch.
  - 16'hFFFF wraps to 16'h0000.
- Storage:
  - Output register `q`/`q_val`/`q_pc`.
  - Skid buffer `buf`/`buf_val`/`buf_pc`.
- States:
  - IDLE: one cycle after reset release.
  - FETCH: `imem_req`=1, awaiting ack.
  - DROP: `imem_req`=1 for a stale request; data is discarded on ack.
  - FULL: buffer occupied; `imem_req`=0.
  - HOLD: `imem_req`=0; waiting for a redirect.
- Transitions:
  - IDLE → FETCH at `RESET_PC`.
  - FETCH, ack, output free or `stall`=0: data → `q`. Stay in FETCH at addr+1.
  - FETCH, ack, `stall`=1 with `q_val`=1: data → `buf`. Go to FULL.
  - FULL, `stall`=0: `buf` → `q`, `buf_val`←0. Go to FETCH at the next PC.
  - FETCH, `redirect_val` without ack: latch `redirect_pc` into `pend_pc`. Go to DROP.
  - DROP, ack: discard data. Go to FETCH at `pend_pc`.
  - DROP, further redirect: overwrite `pend_pc` (latest wins).
  - Any state except DROP, `hold_pc`=1: go to HOLD. A request still pending is completed in DROP-like fashion and its data discarded. HOLD then waits.
  - HOLD, `redirect_val`: go to FETCH at `redirect_pc`.
- Priority: redirect > hold_pc > stall > normal advance.
- Every redirect (or `hold_pc`) clears `q_val` and `buf_val` on the next edge.
- A redirect in the same cycle as ack:
  - The ack data is discarded.
  - The next cycle requests `redirect_pc` (FETCH, not DROP).
- `return_pc`=1 forces `q_val`←0 for that cycle and blocks any transition out of HOLD except via redirect.
- `q` = `NOP_INSN` whenever `q_val`=0.

## Timing
- Reset (asynchronous, immediate) values:
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `q`=`NOP_INSN`, `q_val`=0, `q_pc`=`RESET_PC`.
  - `buf_val`=0, state IDLE.
- First `imem_req`=1 occurs in the 2nd cycle after `rst` deasserts.
- Latency: ack in cycle n gives `q`/`q_val` at edge n+1. The next request, at addr+1, is already on the bus in cycle n+1.
- Zero-wait memory (ack whenever req) sustains 1 instruction/cycle.
- `stall` holds `q` unchanged. At most one extra word is absorbed into `buf`. No word is lost or duplicated.
- Redirect in cycle n with no outstanding request: `imem_addr`=`redirect_pc` in n+1; the first target word appears on `q` at the earliest in n+2.
- Redirect to a pending request: latency equals the remaining ack wait plus one request.
- `hold_pc` in cycle n: `q_val`=0 from n+1. No `imem_req` rises until a redirect.
- Reset mid-request: all state cleared. An ack after reset while `imem_req`=0 is ignored.

## Test plan
- Reset release with zero-wait memory returning addr as data: `q`=0,1,2,3 on consecutive cycles. `q_pc` matches. First `q_val` is 3 cycles after release.
- `stall`=1 for 3 cycles while `q`=16'h0005: `q` holds 5; the word at address 6 goes to `buf`; `imem_req`=0. After `stall`=0: `q`=6, then 7. No gaps or duplicates.
- Memory with 3-cycle ack latency, `redirect_val` with `redirect_pc`=16'h0100 while fetching 16'h0010: address 16'h0010 is held until ack, its data is dropped, the next request is 16'h0100, and `q`=mem[0x100] arrives with `q_pc`=0x100.
- `hold_pc`=1 while `q`=RETURN word: `q_val`=0 next cycle. `imem_req` stays 0 for 5 idle cycles. Redirect to 16'h0040 resumes fetch at 16'h0040.
- PC at 16'hFFFF: the next request is 16'h0000 and `q_pc` wraps.
- Assert `rst`=0 during a pending request at 16'h0022: outputs return to reset values immediately. Fetch restarts at `RESET_PC`; a late ack is ignored.
